// File: rtl/voice_mixer.sv
// Wavetable voice mixer: issues one ROM read per active voice slot after each sample tick
// and sums the returned samples into an unsigned mix.
module voice_mixer #(
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned NUM_NOTES    = 24,
  parameter int unsigned NUM_VOICES   = 8,
  parameter int unsigned SAMPLE_WIDTH = 8,
  parameter int unsigned ROM_LATENCY  = 2
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    sample_tick_in,
  input  logic [ADDR_WIDTH-1:0]   addr_in [NUM_NOTES],
  input  logic [4:0]              active_voices_idx [NUM_VOICES],
  input  logic [3:0]              num_voices_in,
  output logic                    rom_en_out,
  output logic [ADDR_WIDTH+1:0]   rom_addr_out,
  input  logic [SAMPLE_WIDTH-1:0] rom_data_in,
  output logic [SAMPLE_WIDTH+2:0] mix_out,
  output logic [3:0]              mix_voices_out,
  output logic                    mix_valid_out,
  output logic                    busy_out,
  output logic                    overrun_out
);

  localparam int unsigned AccWidth = SAMPLE_WIDTH + 3;
  localparam int unsigned SlotW    = $clog2(NUM_VOICES);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

  state_e                  state_q;
  logic [4:0]              idx_snap_q [NUM_VOICES];
  logic [ADDR_WIDTH-1:0]   addr_snap_q [NUM_NOTES];
  logic [3:0]              n_q;
  logic [3:0]              cnt_q;
  logic [1:0]              drain_q;
  logic [AccWidth-1:0]     acc_q;
  logic [ROM_LATENCY-1:0]  vld_q;

  logic [3:0]              n_clamp;
  logic [4:0]              req_idx;
  logic [4:0]              note_sel;
  logic                    req_valid;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic [AccWidth-1:0]     ret_add;

  // The first request comes straight from the live inputs, later ones from the snapshot.
  always_comb begin
    n_clamp   = (num_voices_in > 4'(NUM_VOICES)) ? 4'(NUM_VOICES) : num_voices_in;
    req_idx   = (state_q == StIdle) ? active_voices_idx[0]
                                    : idx_snap_q[SlotW'(cnt_q + 4'd1)];
    req_valid = 32'(req_idx) < NUM_NOTES;
    note_sel  = req_valid ? req_idx : 5'd0;
    req_addr  = (state_q == StIdle) ? addr_in[note_sel] : addr_snap_q[note_sel];
    ret_add   = vld_q[ROM_LATENCY-1] ? AccWidth'(rom_data_in) : '0;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q        <= StIdle;
      n_q            <= '0;
      cnt_q          <= '0;
      drain_q        <= '0;
      acc_q          <= '0;
      vld_q          <= '0;
      rom_en_out     <= 1'b0;
      rom_addr_out   <= '0;
      mix_out        <= '0;
      mix_voices_out <= '0;
      mix_valid_out  <= 1'b0;
      busy_out       <= 1'b0;
      overrun_out    <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) idx_snap_q[i] <= '0;
      for (int i = 0; i < NUM_NOTES; i++) addr_snap_q[i] <= '0;
    end else begin
      mix_valid_out <= 1'b0;
      // Tags which return cycles carry a real sample.
      vld_q <= (vld_q << 1) | ROM_LATENCY'(rom_en_out);
      unique case (state_q)
        StIdle: begin
          if (sample_tick_in) begin
            idx_snap_q  <= active_voices_idx;
            addr_snap_q <= addr_in;
            n_q         <= n_clamp;
            acc_q       <= '0;
            cnt_q       <= '0;
            busy_out    <= 1'b1;
            if (n_clamp == 4'd0) begin
              state_q <= StDrain;
              drain_q <= '0;
            end else begin
              state_q    <= StIssue;
              rom_en_out <= req_valid;
              if (req_valid) rom_addr_out <= {req_idx[4:3], req_addr};
            end
          end
        end
        StIssue: begin
          acc_q <= acc_q + ret_add;
          if (sample_tick_in) overrun_out <= 1'b1;
          if (cnt_q == n_q - 4'd1) begin
            state_q    <= StDrain;
            drain_q    <= 2'(ROM_LATENCY - 1);
            rom_en_out <= 1'b0;
          end else begin
            cnt_q      <= cnt_q + 4'd1;
            rom_en_out <= req_valid;
            if (req_valid) rom_addr_out <= {req_idx[4:3], req_addr};
          end
        end
        StDrain: begin
          acc_q <= acc_q + ret_add;
          if (sample_tick_in) overrun_out <= 1'b1;
          if (drain_q == 2'd0) begin
            state_q        <= StIdle;
            busy_out       <= 1'b0;
            mix_valid_out  <= 1'b1;
            mix_out        <= acc_q + ret_add;
            mix_voices_out <= n_q;
          end else begin
            drain_q <= drain_q - 2'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_voice_mixer.sv
// Directed bench for voice_mixer with a two-cycle ROM model returning addr[7:0] or 0xFF.
module tb_voice_mixer;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        sample_tick_in;
  logic [7:0]  addr_in [24];
  logic [4:0]  active_voices_idx [8];
  logic [3:0]  num_voices_in;
  logic        rom_en_out;
  logic [9:0]  rom_addr_out;
  logic [7:0]  rom_data_in;
  logic [10:0] mix_out;
  logic [3:0]  mix_voices_out;
  logic        mix_valid_out;
  logic        busy_out;
  logic        overrun_out;

  logic        rom_ff = 1'b0;
  logic [7:0]  rom_s1 = 8'h00;
  int          total = 0;
  int          passed = 0;
  int          en_cnt;
  int          vld_cnt;

  voice_mixer dut (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .sample_tick_in    (sample_tick_in),
    .addr_in           (addr_in),
    .active_voices_idx (active_voices_idx),
    .num_voices_in     (num_voices_in),
    .rom_en_out        (rom_en_out),
    .rom_addr_out      (rom_addr_out),
    .rom_data_in       (rom_data_in),
    .mix_out           (mix_out),
    .mix_voices_out    (mix_voices_out),
    .mix_valid_out     (mix_valid_out),
    .busy_out          (busy_out),
    .overrun_out       (overrun_out)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) begin
    rom_s1      <= rom_ff ? 8'hFF : rom_addr_out[7:0];
    rom_data_in <= rom_s1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_three(input logic [4:0] mid_idx);
    addr_in[2]  = 8'h10;
    addr_in[9]  = 8'h20;
    addr_in[17] = 8'h30;
    active_voices_idx[0] = 5'd2;
    active_voices_idx[1] = mid_idx;
    active_voices_idx[2] = 5'd17;
    num_voices_in = 4'd3;
  endtask

  initial begin
    rst_in = 1'b1;
    sample_tick_in = 1'b0;
    num_voices_in = 4'd0;
    for (int i = 0; i < 24; i++) addr_in[i] = 8'h00;
    for (int i = 0; i < 8; i++) active_voices_idx[i] = 5'h1F;
    #1;
    check("rst_mix", 32'(mix_out), 0);
    check("rst_valid", 32'(mix_valid_out), 0);
    check("rst_busy", 32'(busy_out), 0);
    check("rst_overrun", 32'(overrun_out), 0);
    check("rst_en", 32'(rom_en_out), 0);
    check("rst_addr", 32'(rom_addr_out), 0);
    check("rst_voices", 32'(mix_voices_out), 0);
    next_cycle();
    next_cycle();
    rst_in = 1'b0;
    next_cycle();

    // Three voices across all three tables
    set_three(5'd9);
    sample_tick_in = 1'b1;                     // T
    next_cycle(); sample_tick_in = 1'b0;       // T+1
    check("a_en1", 32'(rom_en_out), 1);
    check("a_addr1", 32'(rom_addr_out), 32'h010);
    check("a_busy1", 32'(busy_out), 1);
    next_cycle();                              // T+2
    check("a_addr2", 32'(rom_addr_out), 32'h120);
    next_cycle();                              // T+3
    check("a_addr3", 32'(rom_addr_out), 32'h230);
    next_cycle();                              // T+4
    check("a_en4", 32'(rom_en_out), 0);
    next_cycle();                              // T+5
    check("a_valid5", 32'(mix_valid_out), 0);
    check("a_busy5", 32'(busy_out), 1);
    next_cycle();                              // T+6
    check("a_valid6", 32'(mix_valid_out), 1);
    check("a_mix", 32'(mix_out), 32'h060);
    check("a_voices", 32'(mix_voices_out), 3);
    check("a_busy6", 32'(busy_out), 0);
    next_cycle();                              // T+7
    check("a_valid7", 32'(mix_valid_out), 0);
    check("a_hold", 32'(mix_out), 32'h060);

    // Tick while busy is dropped; tick in the completion cycle restarts
    sample_tick_in = 1'b1;                     // T
    next_cycle(); sample_tick_in = 1'b0;       // T+1
    next_cycle();                              // T+2
    next_cycle(); sample_tick_in = 1'b1;       // T+3
    next_cycle(); sample_tick_in = 1'b0;       // T+4
    check("b_overrun", 32'(overrun_out), 1);
    next_cycle();                              // T+5
    check("b_valid5", 32'(mix_valid_out), 0);
    next_cycle();                              // T+6
    check("b_valid6", 32'(mix_valid_out), 1);
    check("b_mix", 32'(mix_out), 32'h060);
    num_voices_in = 4'd1;
    sample_tick_in = 1'b1;                     // T' = T+6
    next_cycle(); sample_tick_in = 1'b0;       // T'+1
    check("b_restart_en", 32'(rom_en_out), 1);
    check("b_restart_addr", 32'(rom_addr_out), 32'h010);
    check("b_restart_busy", 32'(busy_out), 1);
    next_cycle(); next_cycle(); next_cycle();  // T'+4
    check("b_one_valid", 32'(mix_valid_out), 1);
    check("b_one_mix", 32'(mix_out), 32'h010);
    check("b_one_voices", 32'(mix_voices_out), 1);
    check("b_sticky", 32'(overrun_out), 1);
    next_cycle();

    // Zero voices
    num_voices_in = 4'd0;
    sample_tick_in = 1'b1;
    next_cycle(); sample_tick_in = 1'b0;       // T+1
    check("c_en", 32'(rom_en_out), 0);
    check("c_busy", 32'(busy_out), 1);
    check("c_valid1", 32'(mix_valid_out), 0);
    next_cycle();                              // T+2
    check("c_valid2", 32'(mix_valid_out), 1);
    check("c_mix", 32'(mix_out), 0);
    check("c_voices", 32'(mix_voices_out), 0);
    check("c_busy2", 32'(busy_out), 0);
    next_cycle();

    // Empty slot inside the active range
    set_three(5'd31);
    sample_tick_in = 1'b1;
    next_cycle(); sample_tick_in = 1'b0;       // T+1
    check("d_addr1", 32'(rom_addr_out), 32'h010);
    next_cycle();                              // T+2
    check("d_en2", 32'(rom_en_out), 0);
    check("d_hold2", 32'(rom_addr_out), 32'h010);
    next_cycle();                              // T+3
    check("d_addr3", 32'(rom_addr_out), 32'h230);
    next_cycle(); next_cycle(); next_cycle();  // T+6
    check("d_valid", 32'(mix_valid_out), 1);
    check("d_mix", 32'(mix_out), 32'h040);
    check("d_voices", 32'(mix_voices_out), 3);
    next_cycle();

    // Full load at max sample, voice count clamped from 12
    rom_ff = 1'b1;
    for (int i = 0; i < 8; i++) active_voices_idx[i] = 5'(i);
    num_voices_in = 4'd12;
    sample_tick_in = 1'b1;
    en_cnt = 0;
    for (int k = 1; k <= 10; k++) begin
      next_cycle(); sample_tick_in = 1'b0;
      if (rom_en_out) en_cnt++;
      check($sformatf("e_busy%0d", k), 32'(busy_out), 1);
    end
    next_cycle();                              // T+11
    check("e_requests", 32'(en_cnt), 8);
    check("e_valid", 32'(mix_valid_out), 1);
    check("e_mix", 32'(mix_out), 32'h7F8);
    check("e_voices", 32'(mix_voices_out), 8);
    check("e_busy11", 32'(busy_out), 0);
    next_cycle();

    // Reset mid-mix abandons the mix
    rom_ff = 1'b0;
    for (int i = 3; i < 8; i++) active_voices_idx[i] = 5'h1F;
    set_three(5'd9);
    sample_tick_in = 1'b1;
    next_cycle(); sample_tick_in = 1'b0;       // T+1
    next_cycle();                              // T+2
    rst_in = 1'b1;
    #1;
    check("f_busy", 32'(busy_out), 0);
    check("f_en", 32'(rom_en_out), 0);
    check("f_overrun", 32'(overrun_out), 0);
    check("f_mix", 32'(mix_out), 0);
    #1 rst_in = 1'b0;
    vld_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      next_cycle();
      if (mix_valid_out) vld_cnt++;
    end
    check("f_no_valid", 32'(vld_cnt), 0);
    check("f_mix_kept", 32'(mix_out), 0);
    sample_tick_in = 1'b1;
    next_cycle(); sample_tick_in = 1'b0;
    for (int k = 2; k <= 6; k++) next_cycle();
    check("f_valid", 32'(mix_valid_out), 1);
    check("f_sum", 32'(mix_out), 32'h060);
    check("f_voices", 32'(mix_voices_out), 3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
